// File: rtl/ai_vector_exec_unit.sv
// AI vector execute stage: 128-bit lane ops, iterative VMUL/DOT/MAC over 4 beats, 32-bit accumulator.
// Single-cycle ops finish 1 cycle after acceptance, iterative ops 5; busy holds the front end while iterating.
module ai_vector_exec_unit #(
  parameter int DATA_W = 128,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              is_ai_in,
  input  logic [2:0]        ai_opcode_in,
  input  logic [DATA_W-1:0] read_data1_in,
  input  logic [DATA_W-1:0] read_data2_in,
  input  logic [4:0]        rd_in,
  input  logic              regwrite_in,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result_out,
  output logic [4:0]        rd_out,
  output logic              regwrite_out,
  output logic [ACC_W-1:0]  acc_out
);

  localparam logic [2:0] OP_VADD = 3'd0, OP_VSUB = 3'd1, OP_VMUL = 3'd2, OP_DOT = 3'd3,
                         OP_RELU = 3'd4, OP_VMAX = 3'd5, OP_MAC = 3'd6, OP_CLRACC = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_a, r_b, r_work, r_result;
  logic [2:0]        r_op;
  logic [4:0]        r_rd, r_rd_out;
  logic              r_we, r_we_out;
  logic [1:0]        r_cnt;
  logic [ACC_W-1:0]  r_acc, r_sum;

  logic              w_accept, w_multi_in, w_last_beat;
  logic [DATA_W-1:0] w_single, w_work_nxt;
  logic [31:0]       w_lane_a, w_lane_b, w_mul_lo;
  logic [ACC_W-1:0]  w_dot_beat, w_sum_nxt, w_acc_mac;

  assign w_accept    = in_valid & is_ai_in & (r_state == S_IDLE);
  assign w_multi_in  = (ai_opcode_in == OP_VMUL) | (ai_opcode_in == OP_DOT) | (ai_opcode_in == OP_MAC);
  assign w_last_beat = (r_state == S_RUN) && (r_cnt == 2'd3);

  always_comb begin : single_op
    logic [31:0] la, lb;
    w_single = '0;
    for (int k = 0; k < 4; k++) begin
      la = read_data1_in[32*k +: 32];
      lb = read_data2_in[32*k +: 32];
      case (ai_opcode_in)
        OP_VADD: w_single[32*k +: 32] = la + lb;
        OP_VSUB: w_single[32*k +: 32] = la - lb;
        OP_RELU: w_single[32*k +: 32] = la[31] ? 32'd0 : la;
        OP_VMAX: w_single[32*k +: 32] = ($signed(la) > $signed(lb)) ? la : lb;
        default: w_single[32*k +: 32] = 32'd0;
      endcase
    end
  end

  // One 32-bit lane (four bytes) of the latched operands is consumed per beat.
  assign w_lane_a = r_a[{r_cnt, 5'b0} +: 32];
  assign w_lane_b = r_b[{r_cnt, 5'b0} +: 32];
  assign w_mul_lo = w_lane_a * w_lane_b;

  always_comb begin : dot_beat
    logic signed [15:0] p;
    w_dot_beat = '0;
    for (int j = 0; j < 4; j++) begin
      p = $signed(w_lane_a[8*j +: 8]) * $signed(w_lane_b[8*j +: 8]);
      w_dot_beat = w_dot_beat + {{(ACC_W-16){p[15]}}, p};
    end
  end

  always_comb begin
    w_work_nxt = r_work;
    w_work_nxt[{r_cnt, 5'b0} +: 32] = w_mul_lo;
  end

  assign w_sum_nxt = r_sum + w_dot_beat;
  assign w_acc_mac = r_acc + w_sum_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_multi_in ? S_RUN : S_DONE;
      S_RUN:   if (r_cnt == 2'd3) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_we     <= 1'b0;
      r_rd_out <= '0;
      r_we_out <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_sum    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a    <= read_data1_in;
        r_b    <= read_data2_in;
        r_op   <= ai_opcode_in;
        r_rd   <= rd_in;
        r_we   <= regwrite_in;
        r_cnt  <= '0;
        r_work <= '0;
        r_sum  <= '0;
        if (!w_multi_in) begin
          r_result <= w_single;
          r_rd_out <= rd_in;
          r_we_out <= regwrite_in & (rd_in != 5'd0);
          if (ai_opcode_in == OP_CLRACC) r_acc <= '0;
        end
      end
      if (r_state == S_RUN) begin
        r_cnt  <= r_cnt + 2'd1;
        r_work <= w_work_nxt;
        r_sum  <= w_sum_nxt;
      end
      if (w_last_beat) begin
        r_rd_out <= r_rd;
        r_we_out <= r_we & (r_rd != 5'd0);
        case (r_op)
          OP_VMUL: r_result <= w_work_nxt;
          OP_MAC: begin
            r_acc    <= w_acc_mac;
            r_result <= {{(DATA_W-ACC_W){1'b0}}, w_acc_mac};
          end
          default: r_result <= {{(DATA_W-ACC_W){1'b0}}, w_sum_nxt};
        endcase
      end
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign busy         = (r_state == S_RUN);
  assign done         = (r_state == S_DONE);
  assign result_out   = r_result;
  assign rd_out       = r_rd_out;
  assign regwrite_out = r_we_out;
  assign acc_out      = r_acc;

endmodule

// File: tb/tb_ai_vector_exec_unit.sv
// Directed bench for ai_vector_exec_unit: hand-computed vectors, latency, stall and reset-abort checks.
module tb_ai_vector_exec_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         is_ai_in;
  logic [2:0]   ai_opcode_in;
  logic [127:0] read_data1_in;
  logic [127:0] read_data2_in;
  logic [4:0]   rd_in;
  logic         regwrite_in;
  logic         in_ready;
  logic         busy;
  logic         done;
  logic [127:0] result_out;
  logic [4:0]   rd_out;
  logic         regwrite_out;
  logic [31:0]  acc_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ai_vector_exec_unit #(.DATA_W(128), .ACC_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .is_ai_in      (is_ai_in),
    .ai_opcode_in  (ai_opcode_in),
    .read_data1_in (read_data1_in),
    .read_data2_in (read_data2_in),
    .rd_in         (rd_in),
    .regwrite_in   (regwrite_in),
    .in_ready      (in_ready),
    .busy          (busy),
    .done          (done),
    .result_out    (result_out),
    .rd_out        (rd_out),
    .regwrite_out  (regwrite_out),
    .acc_out       (acc_out)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one instruction and observe 8 cycles after the acceptance edge.
  task automatic run_op(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b,
                        input logic [4:0] rd, input logic we, input bit hold,
                        output int done_cyc, output int busy_n, output int done_n, output int rdy_bad);
    done_cyc = 0; busy_n = 0; done_n = 0; rdy_bad = 0;
    in_valid = 1'b1; is_ai_in = 1'b1; ai_opcode_in = op;
    read_data1_in = a; read_data2_in = b; rd_in = rd; regwrite_in = we;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (done) begin
        done_n++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (busy) busy_n++;
      if ((busy || done) && in_ready) rdy_bad++;
      if (c == 5) in_valid = 1'b0;
      if (c < 8) begin @(posedge clk); #1; end
    end
  endtask

  task automatic exec(input string name, input logic [2:0] op, input logic [127:0] a, input logic [127:0] b,
                      input logic [4:0] rd, input logic we, input bit hold,
                      input logic [127:0] exp_res, input logic [31:0] exp_acc, input logic exp_we);
    int dc, bn, dn, rb;
    bit multi;
    multi = (op == 3'd2) || (op == 3'd3) || (op == 3'd6);
    run_op(op, a, b, rd, we, hold, dc, bn, dn, rb);
    check({name, "_done_cycle"}, 128'(dc), multi ? 128'd5 : 128'd1);
    check({name, "_done_pulses"}, 128'(dn), 128'd1);
    check({name, "_busy_cycles"}, 128'(bn), multi ? 128'd4 : 128'd0);
    check({name, "_ready_while_active"}, 128'(rb), 128'd0);
    check({name, "_result"}, result_out, exp_res);
    check({name, "_acc"}, 128'(acc_out), 128'(exp_acc));
    check({name, "_rd"}, 128'(rd_out), 128'(rd));
    check({name, "_regwrite"}, 128'(regwrite_out), 128'(exp_we));
  endtask

  initial begin
    int dn, bn;
    reset = 1'b1; in_valid = 1'b0; is_ai_in = 1'b0; ai_opcode_in = 3'd0;
    read_data1_in = '0; read_data2_in = '0; rd_in = '0; regwrite_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_done", 128'(done), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_ready", 128'(in_ready), 128'd1);
    check("rst_result", result_out, 128'd0);
    check("rst_acc", 128'(acc_out), 128'd0);
    check("rst_rd_we", 128'({rd_out, regwrite_out}), 128'd0);

    exec("vadd", 3'd0, 128'hFFFFFFFF_00000003_00000002_00000001, 128'h00000001_00000001_00000001_00000001,
         5'd5, 1'b1, 1'b0, 128'h00000000_00000004_00000003_00000002, 32'd0, 1'b1);
    exec("vmul", 3'd2, 128'h00010000_00000007_00000005_00000002, 128'h00010000_00000006_00000004_00000003,
         5'd6, 1'b1, 1'b0, 128'h00000000_0000002A_00000014_00000006, 32'd0, 1'b1);
    exec("dot", 3'd3, {16{8'h02}}, {16{8'hFF}},
         5'd7, 1'b1, 1'b0, 128'h00000000_00000000_00000000_FFFFFFE0, 32'd0, 1'b1);
    exec("mac1", 3'd6, {16{8'h01}}, {16{8'h03}}, 5'd8, 1'b1, 1'b0, 128'd48, 32'd48, 1'b1);
    exec("mac2", 3'd6, {16{8'h01}}, {16{8'h03}}, 5'd8, 1'b1, 1'b0, 128'd96, 32'd96, 1'b1);
    exec("clracc", 3'd7, {16{8'h11}}, {16{8'h22}}, 5'd9, 1'b0, 1'b0, 128'd0, 32'd0, 1'b0);
    exec("relu", 3'd4, 128'h80000000_00000005_FFFFFFFF_00000000, {4{32'h7FFFFFFF}},
         5'd10, 1'b1, 1'b0, 128'h00000000_00000005_00000000_00000000, 32'd0, 1'b1);
    exec("vmax", 3'd5, 128'h00000000_00000000_FFFFFFFF_00000002, 128'h00000000_00000000_00000001_FFFFFFFD,
         5'd11, 1'b1, 1'b0, 128'h00000000_00000000_00000001_00000002, 32'd0, 1'b1);
    exec("vsub", 3'd1, 128'h00000000_00000010_00000005_00000001, 128'h00000001_00000001_00000002_00000001,
         5'd12, 1'b1, 1'b0, 128'hFFFFFFFF_0000000F_00000003_00000000, 32'd0, 1'b1);
    exec("vadd_rd0", 3'd0, 128'd1, 128'd2, 5'd0, 1'b1, 1'b0, 128'd3, 32'd0, 1'b0);
    // in_valid held through RUN and DONE must not be re-accepted
    exec("vmul_hold", 3'd2, 128'h00000002_00000003_FFFFFFFF_80000000, 128'h00000003_00000004_00000002_00000002,
         5'd13, 1'b1, 1'b1, 128'h00000006_0000000C_FFFFFFFE_00000000, 32'd0, 1'b1);

    // Non-AI instruction is ignored.
    in_valid = 1'b1; is_ai_in = 1'b0; ai_opcode_in = 3'd7;
    read_data1_in = 128'd9; read_data2_in = 128'd9; rd_in = 5'd3; regwrite_in = 1'b1;
    dn = 0; bn = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done) dn++;
      if (busy) bn++;
    end
    in_valid = 1'b0;
    check("nonai_done", 128'(dn), 128'd0);
    check("nonai_busy", 128'(bn), 128'd0);
    check("nonai_result", result_out, 128'h00000006_0000000C_FFFFFFFE_00000000);
    check("nonai_rd", 128'(rd_out), 128'd13);

    // MAC to make acc nonzero, then VMUL aborted by reset during beat 2.
    exec("mac3", 3'd6, {16{8'h01}}, {16{8'h01}}, 5'd4, 1'b1, 1'b0, 128'd16, 32'd16, 1'b1);
    in_valid = 1'b1; is_ai_in = 1'b1; ai_opcode_in = 3'd2;
    read_data1_in = {4{32'd3}}; read_data2_in = {4{32'd5}}; rd_in = 5'd2; regwrite_in = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_busy_before", 128'(busy), 128'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_ready", 128'(in_ready), 128'd1);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_done", 128'(done), 128'd0);
    check("abort_result", result_out, 128'd0);
    check("abort_acc", 128'(acc_out), 128'd0);
    check("abort_rd_we", 128'({rd_out, regwrite_out}), 128'd0);
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done || busy) dn++;
    end
    check("abort_no_done", 128'(dn), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ai_vector_exec_unit.md
Name: ai_vector_exec_unit

Overview:
- Execute-stage consumer of the ID/EX pipeline register's AI fields: is_ai, ai_opcode, the 128-bit read_data1/read_data2, and rd/regwrite.
- Runs the 3-bit AI opcode set on 128-bit vector operands.
- Single-cycle ops complete in 1 cycle; multiply and dot-product ops are iterative.
- While an op is in flight, `busy` stalls the front end, which holds the ID/EX register. On completion the block delivers a registered result, destination register and write enable toward EX/MEM.

Parameters:
- DATA_W, 128, vector operand/result width; fixed at 128 (4 lanes x 32 bit, or 16 lanes x 8 bit).
- ACC_W, 32, width of the MAC accumulator; wraps modulo 2^32.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  ID/EX holds a live instruction
- is_ai_in  input  1  instruction is an AI op
- ai_opcode_in  input  3  AI operation select
- read_data1_in  input  128  operand A
- read_data2_in  input  128  operand B
- rd_in  input  5  destination register
- regwrite_in  input  1  destination write enable
- in_ready  output  1  high only in IDLE
- busy  output  1  stall request to front end/ID-EX hold
- done  output  1  one-cycle pulse; result fields valid
- result_out  output  128  computed vector
- rd_out  output  5  destination of completed op
- regwrite_out  output  1  write enable of completed op
- acc_out  output  32  current accumulator value

Behaviour:
- One clock domain; reset is synchronous and active-high. The clock is named clk and the reset is named reset.
- Reset values:
  - state = IDLE, and the accumulator is 0.
  - done, busy, regwrite_out, result_out, rd_out and acc_out are all 0.
  - in_ready = 1 from the first cycle after reset.
- Acceptance:
  - An instruction is accepted at edge N when in_valid & is_ai_in & in_ready.
  - On acceptance the block latches operands, opcode, rd and regwrite.
  - Instructions with is_ai_in = 0 are ignored; state and outputs are unchanged.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> DONE on accepting a single-cycle op.
  - IDLE -> RUN on accepting a multi-cycle op; the 2-bit beat counter is cleared to 0.
  - RUN processes one beat per cycle. On the edge where the counter is 3, the state moves to DONE, so RUN lasts 4 cycles.
  - DONE -> IDLE unconditionally; DONE never accepts a new instruction.
- Latency after acceptance at edge N:
  - Single-cycle ops: done is high in cycle N+1.
  - Multi-cycle ops: done is high in cycle N+5.
- Output timing:
  - busy = (state == RUN), so it is high for exactly 4 cycles per multi-cycle op.
  - done = (state == DONE).
  - result_out, rd_out and regwrite_out update when DONE is entered and hold until the next DONE or reset.
- regwrite_out = latched regwrite & (latched rd != 0).
- Opcodes (lanes are 32-bit unless stated):
  - 0 VADD: lane-wise add, modulo 2^32.
  - 1 VSUB: lane-wise A-B, modulo 2^32.
  - 2 VMUL: multi-cycle. Beat k computes lane k as the low 32 bits of A[k]*B[k], unsigned.
  - 3 DOT: multi-cycle. Beat k sums the signed 8x8 products of bytes 4k..4k+3 into a 32-bit partial sum.
    - Result is the 32-bit sum in [31:0]; bits [127:32] are 0.
    - The accumulator is untouched.
  - 4 RELU: per signed lane, max(0, A[k]); B is ignored.
  - 5 VMAX: per lane, signed max(A[k], B[k]).
  - 6 MAC: multi-cycle. Computes the DOT sum, then acc <= acc + sum when DONE is entered.
    - result_out[31:0] = the new acc; upper bits are 0.
  - 7 CLRACC: single-cycle. acc <= 0, and result_out = 0.
- acc_out mirrors the accumulator register.
- Boundaries:
  - in_valid held high while in RUN or DONE is not accepted. The front end must hold the instruction using busy/in_ready.
  - Reset asserted mid-RUN aborts the op, returns to reset values next cycle and produces no done pulse.
  - Overflow in every op wraps silently; there are no flags.
  - A 0x80000000 lane passes RELU as 0.

Test Plan:
- Reset then VADD, A lanes {0xFFFFFFFF,3,2,1} (lane3..0), B all 1 -> done at N+1, result {0x00000000,4,3,2}, busy never high, in_ready low during DONE.
- VMUL, A lanes {0x10000,7,5,2}, B {0x10000,6,4,3} -> busy high cycles N+1..N+4, done at N+5, result {0,42,20,6}.
- DOT, A all bytes 0x02, B all bytes 0xFF -> result_out = 0x...00_FFFFFFE0 (-32), acc_out unchanged at 0.
- MAC twice with A bytes 0x01 and B bytes 0x03 -> acc_out 48 then 96, result[31:0] tracks acc; CLRACC then gives acc_out 0 at N+1.
- RELU {0x80000000,5,0xFFFFFFFF,0} -> {0,5,0,0}; VMAX A {-1,2}, B {1,-3} in the low lanes -> {1,2}.
- VMUL accepted, reset asserted at RUN beat 2 -> next cycle state IDLE, all outputs 0, no done pulse. Also drive rd_in = 0 with regwrite_in = 1 on a VADD -> regwrite_out 0.
